// File: rtl/cnn_input_ctrl.sv
// Input-side controller for the CNN core: loads a packed binary frame into the input RAM,
// then scans it as 3x3 windows addressed by their bottom-right pixel.
module cnn_input_ctrl #(
    parameter int unsigned IMG_W = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_vld,
    input  logic [7:0] in_data,
    output logic       in_rdy,
    output logic       ram_en,
    output logic [7:0] ram_din,
    output logic [9:0] ram_addr_wr,
    output logic       ram_rd,
    output logic [9:0] ram_addr_rd,
    output logic       win_vld,
    input  logic       win_rdy,
    output logic [4:0] win_row,
    output logic [4:0] win_col,
    output logic       win_last,
    output logic       busy,
    output logic       done
);

    localparam logic [6:0] LastByte = 7'(IMG_W * IMG_W / 8 - 1);
    localparam logic [4:0] LastCol  = 5'(IMG_W - 3);
    localparam logic [9:0] FirstRd  = 10'(2 * IMG_W + 2);

    typedef enum logic [1:0] {StIdle, StLoad, StConv, StDone} state_e;

    state_e     state_q, state_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [9:0] addr_rd_q, addr_rd_d;
    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            addr_rd_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_rd_q  <= addr_rd_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_rd_d  = addr_rd_q;
        row_d      = row_q;
        col_d      = col_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLoad;
                    byte_cnt_d = '0;
                end
            end
            StLoad: begin
                if (in_vld) begin
                    byte_cnt_d = byte_cnt_q + 7'd1;
                    if (byte_cnt_q == LastByte) begin
                        state_d   = StConv;
                        addr_rd_d = FirstRd;
                        row_d     = '0;
                        col_d     = '0;
                    end
                end
            end
            StConv: begin
                if (win_rdy) begin
                    if (win_last) begin
                        state_d = StDone;
                    end else if (col_q == LastCol) begin
                        // Jump over the two left border columns of the next row
                        addr_rd_d = addr_rd_q + 10'd3;
                        col_d     = '0;
                        row_d     = row_q + 5'd1;
                    end else begin
                        addr_rd_d = addr_rd_q + 10'd1;
                        col_d     = col_q + 5'd1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign in_rdy      = (state_q == StLoad);
    assign ram_en      = in_vld & in_rdy;
    assign ram_din     = in_data;
    assign ram_addr_wr = {byte_cnt_q, 3'b000};
    assign win_vld     = (state_q == StConv);
    assign ram_rd      = win_vld;
    assign ram_addr_rd = addr_rd_q;
    assign win_row     = row_q;
    assign win_col     = col_q;
    assign win_last    = win_vld && (row_q == LastCol) && (col_q == LastCol);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule
